// File: rtl/umi_fifo_sync.sv
//----------------------------------------------------------------------------
// umi_fifo_sync
//
// Single-clock UMI FIFO with arbitrary (non-power-of-two) depth, a live
// occupancy count and a programmable almost-full threshold. The FIFO has
// first-word fall-through: the head entry is shown on umi_out_* while
// umi_out_valid is high. A combinational bypass path connects the input
// directly to the output without touching the stored contents.
//
// Optional feature (macro UMI_FIFO_SYNC_CHAOS_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   stalls umi_in_ready pseudo-randomly while chaosmode is high. This lets
//   verification exercise producer backpressure. When undefined, no LFSR is
//   built and chaosmode is ignored.
//
// Parameters:
//   DEPTH       number of entries (>= 2)
//   ALMOSTFULL  occupancy at which fifo_almost_full asserts (1..DEPTH)
//   AW, CW, DW  UMI address, command and data widths
//   CNTW        width of fifo_count
//
// Ports:
//   clk               single clock for all logic
//   reset             synchronous active-high reset
//   bypass            1 = combinational pass-through, FIFO frozen
//   chaosmode         enables pseudo-random input pushback (macro builds)
//   fifo_full         count == DEPTH
//   fifo_almost_full  count >= ALMOSTFULL
//   fifo_empty        count == 0
//   fifo_count        current occupancy
//   umi_in_*          producer side (valid/cmd/dstaddr/srcaddr/data/ready)
//   umi_out_*         consumer side (valid/cmd/dstaddr/srcaddr/data/ready)
//----------------------------------------------------------------------------
module umi_fifo_sync #(
  parameter int DEPTH      = 4,
  parameter int ALMOSTFULL = DEPTH - 1,
  parameter int AW         = 64,
  parameter int CW         = 32,
  parameter int DW         = 256,
  parameter int CNTW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bypass,
  input  logic            chaosmode,
  output logic            fifo_full,
  output logic            fifo_almost_full,
  output logic            fifo_empty,
  output logic [CNTW-1:0] fifo_count,
  input  logic            umi_in_valid,
  input  logic [CW-1:0]   umi_in_cmd,
  input  logic [AW-1:0]   umi_in_dstaddr,
  input  logic [AW-1:0]   umi_in_srcaddr,
  input  logic [DW-1:0]   umi_in_data,
  output logic            umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  // Entry layout is {data, srcaddr, dstaddr, cmd} with cmd in the LSBs.
  localparam int EW = DW + AW + AW + CW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNTW-1:0] FULL_COUNT   = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] ALMOST_COUNT = CNTW'(ALMOSTFULL);
  localparam logic [CNTW-1:0] ONE_COUNT    = CNTW'(1);
  localparam logic [PW-1:0]   LAST_PTR     = PW'(DEPTH - 1);
  localparam logic [PW-1:0]   ONE_PTR      = PW'(1);

  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CNTW-1:0] r_count;

  logic            w_stall;
  logic            w_fifoInReady;
  logic            w_fifoOutValid;
  logic            w_write;
  logic            w_read;
  logic [EW-1:0]   w_inWord;
  logic [EW-1:0]   w_headWord;

  // Pseudo-random pushback source. The LFSR free-runs every cycle, including
  // in bypass; the stall it produces only gates the FIFO-side ready, so it
  // has no effect while bypass owns the ready path.
`ifdef UMI_FIFO_SYNC_CHAOS_EN
  logic [15:0] r_lfsr;
  logic        w_lfsrFeedback;

  assign w_lfsrFeedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsrFeedback};
    end
  end

  assign w_stall = chaosmode & r_lfsr[0];
`else
  logic w_unusedChaos;

  assign w_unusedChaos = chaosmode;
  assign w_stall       = 1'b0;
`endif

  // Status flags are pure decodes of the registered count, so they only move
  // on clock edges.
  assign fifo_count       = r_count;
  assign fifo_full        = (r_count == FULL_COUNT);
  assign fifo_empty       = (r_count == '0);
  assign fifo_almost_full = (r_count >= ALMOST_COUNT);

  // FIFO-side handshake. Ready deliberately ignores any read in the same
  // cycle, so a full FIFO never accepts a beat even while draining. Holding
  // ready low during reset keeps the producer from believing a beat was
  // taken on the reset edge.
  assign w_fifoInReady  = ~fifo_full & ~w_stall & ~reset;
  assign w_fifoOutValid = ~fifo_empty;

  assign w_write = ~bypass & umi_in_valid & w_fifoInReady;
  assign w_read  = ~bypass & w_fifoOutValid & umi_out_ready;

  assign w_inWord   = {umi_in_data, umi_in_srcaddr, umi_in_dstaddr, umi_in_cmd};
  assign w_headWord = r_mem[r_rdPtr];

  // Output steering: in bypass every output is a wire from the opposite
  // side; otherwise the head entry falls through combinationally.
  always_comb begin
    umi_in_ready    = w_fifoInReady;
    umi_out_valid   = w_fifoOutValid;
    umi_out_cmd     = w_headWord[CW-1:0];
    umi_out_dstaddr = w_headWord[CW +: AW];
    umi_out_srcaddr = w_headWord[CW+AW +: AW];
    umi_out_data    = w_headWord[CW+AW+AW +: DW];
    if (bypass) begin
      umi_in_ready    = umi_out_ready;
      umi_out_valid   = umi_in_valid;
      umi_out_cmd     = umi_in_cmd;
      umi_out_dstaddr = umi_in_dstaddr;
      umi_out_srcaddr = umi_in_srcaddr;
      umi_out_data    = umi_in_data;
    end
  end

  // Storage array. Contents are never reset; the count alone decides which
  // entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wrPtr] <= w_inWord;
    end
  end

  // Write pointer. The wrap is an explicit compare against DEPTH-1 so that
  // non-power-of-two depths cycle through exactly DEPTH slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
    end else if (w_write) begin
      if (r_wrPtr == LAST_PTR) begin
        r_wrPtr <= '0;
      end else begin
        r_wrPtr <= r_wrPtr + ONE_PTR;
      end
    end
  end

  // Read pointer, wrapping the same way as the write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
    end else if (w_read) begin
      if (r_rdPtr == LAST_PTR) begin
        r_rdPtr <= '0;
      end else begin
        r_rdPtr <= r_rdPtr + ONE_PTR;
      end
    end
  end

  // Occupancy count. A simultaneous read and write cancel out. Write is
  // impossible when full and read impossible when empty, so the count stays
  // within 0..DEPTH without extra saturation logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + ONE_COUNT;
        2'b01:   r_count <= r_count - ONE_COUNT;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sanity properties on the occupancy bookkeeping.
  assertCountBound: assert property (@(posedge clk) disable iff (reset)
    r_count <= FULL_COUNT);

  assertNoWriteWhenFull: assert property (@(posedge clk) disable iff (reset)
    fifo_full |-> !w_write);

  assertNoReadWhenEmpty: assert property (@(posedge clk) disable iff (reset)
    fifo_empty |-> !w_read);

endmodule

// File: tb/tb_umi_fifo_sync.sv
//----------------------------------------------------------------------------
// tb_umi_fifo_sync
//
// Self-checking bench for umi_fifo_sync (DEPTH=5, ALMOSTFULL=3). A directed
// vector table covers fill/drain, full, bypass, simultaneous read/write and
// reset mid-stream; a hand-written stream covers pointer wrap; a randomized
// phase compares against a queue-based reference model. When built with
// UMI_FIFO_SYNC_CHAOS_EN a chaos-mode phase checks stream integrity under
// pseudo-random pushback.
//----------------------------------------------------------------------------
module tb_umi_fifo_sync;

  localparam int DEPTH      = 5;
  localparam int ALMOSTFULL = 3;
  localparam int AW         = 16;
  localparam int CW         = 8;
  localparam int DW         = 32;
  localparam int CNTW       = $clog2(DEPTH + 1);

  logic            clk;
  logic            reset;
  logic            bypass;
  logic            chaosmode;
  logic            fifoFull;
  logic            fifoAlmostFull;
  logic            fifoEmpty;
  logic [CNTW-1:0] fifoCount;
  logic            inValid;
  logic [CW-1:0]   inCmd;
  logic [AW-1:0]   inDst;
  logic [AW-1:0]   inSrc;
  logic [DW-1:0]   inData;
  logic            inReady;
  logic            outValid;
  logic [CW-1:0]   outCmd;
  logic [AW-1:0]   outDst;
  logic [AW-1:0]   outSrc;
  logic [DW-1:0]   outData;
  logic            outReady;

  int nChecks = 0;
  int nErrors = 0;

  umi_fifo_sync #(
    .DEPTH(DEPTH), .ALMOSTFULL(ALMOSTFULL), .AW(AW), .CW(CW), .DW(DW), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bypass(bypass),
    .chaosmode(chaosmode),
    .fifo_full(fifoFull),
    .fifo_almost_full(fifoAlmostFull),
    .fifo_empty(fifoEmpty),
    .fifo_count(fifoCount),
    .umi_in_valid(inValid),
    .umi_in_cmd(inCmd),
    .umi_in_dstaddr(inDst),
    .umi_in_srcaddr(inSrc),
    .umi_in_data(inData),
    .umi_in_ready(inReady),
    .umi_out_valid(outValid),
    .umi_out_cmd(outCmd),
    .umi_out_dstaddr(outDst),
    .umi_out_srcaddr(outSrc),
    .umi_out_data(outData),
    .umi_out_ready(outReady)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          byp;
    logic          vld;
    logic [CW-1:0] cmd;
    logic          ordy;
    int            eCount;
    logic          eFull;
    logic          eAf;
    logic          eEmpty;
    logic          eInRdy;
    logic          eOutVld;
    logic [CW-1:0] eCmd;
  } vec_t;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  vec_t  vecs[$];
  beat_t model[$];

  function automatic vec_t mk(logic rst, logic byp, logic vld, logic [CW-1:0] cmd,
                              logic ordy, int eCount, logic eFull, logic eAf,
                              logic eEmpty, logic eInRdy, logic eOutVld,
                              logic [CW-1:0] eCmd);
    vec_t v;
    v.rst = rst; v.byp = byp; v.vld = vld; v.cmd = cmd; v.ordy = ordy;
    v.eCount = eCount; v.eFull = eFull; v.eAf = eAf; v.eEmpty = eEmpty;
    v.eInRdy = eInRdy; v.eOutVld = eOutVld; v.eCmd = eCmd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; checks follow #1 later,
  // well before the next rising edge.
  task automatic applyStimulus(input logic rst, input logic byp, input logic vld,
                               input beat_t b, input logic ordy, input logic chaos);
    @(negedge clk);
    reset     = rst;
    bypass    = byp;
    inValid   = vld;
    inCmd     = b.cmd;
    inDst     = b.dst;
    inSrc     = b.src;
    inData    = b.data;
    outReady  = ordy;
    chaosmode = chaos;
    #1;
  endtask

  function automatic beat_t beatOf(logic [CW-1:0] cmd);
    beat_t b;
    b.cmd  = cmd;
    b.dst  = {8'hD0, cmd};
    b.src  = {8'h50, cmd};
    b.data = {cmd, cmd, cmd, cmd};
    return b;
  endfunction

  function automatic beat_t randomBeat();
    beat_t b;
    b.cmd  = CW'($urandom);
    b.dst  = AW'($urandom);
    b.src  = AW'($urandom);
    b.data = DW'($urandom);
    return b;
  endfunction

  // Compare all DUT status and handshake outputs against the reference
  // queue; head payload is compared only while a beat is expected.
  task automatic checkAgainstModel(input string tag, input logic rst,
                                   input logic readyKnown);
    int sz;
    sz = model.size();
    checkOutput({tag, "_count"}, 64'(fifoCount), 64'(sz));
    checkOutput({tag, "_full"}, 64'(fifoFull), 64'(sz == DEPTH));
    checkOutput({tag, "_afull"}, 64'(fifoAlmostFull), 64'(sz >= ALMOSTFULL));
    checkOutput({tag, "_empty"}, 64'(fifoEmpty), 64'(sz == 0));
    checkOutput({tag, "_outvalid"}, 64'(outValid), 64'(sz != 0));
    if (readyKnown) begin
      checkOutput({tag, "_inready"}, 64'(inReady), 64'(!rst && sz < DEPTH));
    end else if (rst || sz == DEPTH) begin
      checkOutput({tag, "_inready_blocked"}, 64'(inReady), 64'(0));
    end
    if (sz != 0) begin
      checkOutput({tag, "_cmd"}, 64'(outCmd), 64'(model[0].cmd));
      checkOutput({tag, "_dst"}, 64'(outDst), 64'(model[0].dst));
      checkOutput({tag, "_src"}, 64'(outSrc), 64'(model[0].src));
      checkOutput({tag, "_data"}, 64'(outData), 64'(model[0].data));
    end
  endtask

  initial begin
    beat_t b;
    beat_t idle;
    logic  vld;
    logic  ordy;
    logic  rst;
    logic  wr;
    logic  rd;
    int    stallSeen;
    int    guard;

    idle      = beatOf(8'h00);
    reset     = 1'b1;
    bypass    = 1'b0;
    chaosmode = 1'b0;
    inValid   = 1'b0;
    inCmd     = '0;
    inDst     = '0;
    inSrc     = '0;
    inData    = '0;
    outReady  = 1'b0;

    //           rst byp vld cmd    ordy cnt full af empty inR outV eCmd
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00));
    // Fill to full with the consumer stalled.
    vecs.push_back(mk(0, 0, 1, 8'h01, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h02, 0, 1, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(0, 0, 1, 8'h03, 0, 2, 0, 0, 0, 1, 1, 8'h01));
    vecs.push_back(mk(0, 0, 1, 8'h04, 0, 3, 0, 1, 0, 1, 1, 8'h01));
    vecs.push_back(mk(0, 0, 1, 8'h05, 0, 4, 0, 1, 0, 1, 1, 8'h01));
    // Full while reading: ready stays low, beat 6 is not taken.
    vecs.push_back(mk(0, 0, 1, 8'h06, 1, 5, 1, 1, 0, 0, 1, 8'h01));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 0, 1, 0, 1, 1, 8'h02));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0, 1, 0, 1, 1, 8'h03));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 8'h04));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 8'h05));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h00));
    // Store two entries, then bypass around them.
    vecs.push_back(mk(0, 0, 1, 8'h11, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h12, 0, 1, 0, 0, 0, 1, 1, 8'h11));
    vecs.push_back(mk(0, 1, 1, 8'hAA, 1, 2, 0, 0, 0, 1, 1, 8'hAA));
    vecs.push_back(mk(0, 1, 1, 8'hAB, 0, 2, 0, 0, 0, 0, 1, 8'hAB));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 2, 0, 0, 0, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 8'h11));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 8'h12));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h00));
    // Simultaneous read and write at count 2.
    vecs.push_back(mk(0, 0, 1, 8'h21, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h22, 0, 1, 0, 0, 0, 1, 1, 8'h21));
    vecs.push_back(mk(0, 0, 1, 8'h23, 1, 2, 0, 0, 0, 1, 1, 8'h21));
    vecs.push_back(mk(0, 0, 1, 8'h24, 0, 2, 0, 0, 0, 1, 1, 8'h22));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 3, 0, 1, 0, 1, 1, 8'h22));
    // Reset mid-stream with a beat presented.
    vecs.push_back(mk(1, 0, 1, 8'h33, 0, 3, 0, 1, 0, 0, 1, 8'h22));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h00));

    // Initial reset edge so the first table row sees defined state.
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].byp, vecs[i].vld, beatOf(vecs[i].cmd),
                    vecs[i].ordy, 1'b0);
      checkOutput($sformatf("vec%0d_count", i), 64'(fifoCount), 64'(vecs[i].eCount));
      checkOutput($sformatf("vec%0d_full", i), 64'(fifoFull), 64'(vecs[i].eFull));
      checkOutput($sformatf("vec%0d_afull", i), 64'(fifoAlmostFull), 64'(vecs[i].eAf));
      checkOutput($sformatf("vec%0d_empty", i), 64'(fifoEmpty), 64'(vecs[i].eEmpty));
      checkOutput($sformatf("vec%0d_inready", i), 64'(inReady), 64'(vecs[i].eInRdy));
      checkOutput($sformatf("vec%0d_outvalid", i), 64'(outValid), 64'(vecs[i].eOutVld));
      if (vecs[i].eOutVld) begin
        checkOutput($sformatf("vec%0d_cmd", i), 64'(outCmd), 64'(vecs[i].eCmd));
      end
    end

    // Streaming through an empty FIFO wraps both pointers twice; each beat
    // emerges exactly one cycle after it was written.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, beatOf(CW'(8'h40 + i)), 1'b1, 1'b0);
      checkOutput($sformatf("wrap%0d_count", i), 64'(fifoCount), 64'((i == 0) ? 0 : 1));
      checkOutput($sformatf("wrap%0d_outvalid", i), 64'(outValid), 64'(i != 0));
      checkOutput($sformatf("wrap%0d_inready", i), 64'(inReady), 64'(1));
      if (i != 0) begin
        checkOutput($sformatf("wrap%0d_cmd", i), 64'(outCmd), 64'(8'h40 + i - 1));
        checkOutput($sformatf("wrap%0d_data", i), 64'(outData),
                    64'({4{CW'(8'h40 + i - 1)}}));
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1, 1'b0);
    checkOutput("wrap_last_cmd", 64'(outCmd), 64'(8'h4B));
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1, 1'b0);
    checkOutput("wrap_drained_empty", 64'(fifoEmpty), 64'(1));

    // Randomized traffic against the queue model. chaosmode is toggled
    // randomly only where it must have no effect.
    model.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst  = ($urandom_range(0, 49) == 0);
      vld  = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < ((cyc < 300) ? 35 : 70));
      b    = randomBeat();
`ifdef UMI_FIFO_SYNC_CHAOS_EN
      applyStimulus(rst, 1'b0, vld, b, ordy, 1'b0);
`else
      applyStimulus(rst, 1'b0, vld, b, ordy, 1'($urandom));
`endif
      checkAgainstModel("rand", rst, 1'b1);
      if (rst) begin
        model.delete();
      end else begin
        wr = vld && (model.size() < DEPTH);
        rd = ordy && (model.size() != 0);
        if (rd) void'(model.pop_front());
        if (wr) model.push_back(b);
      end
    end

`ifdef UMI_FIFO_SYNC_CHAOS_EN
    // Chaos mode: ready is unpredictable, so acceptance follows the DUT's
    // handshake while the stream itself is checked against the model.
    applyStimulus(1'b1, 1'b0, 1'b0, idle, 1'b0, 1'b1);
    model.delete();
    stallSeen = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      ordy = ($urandom_range(0, 99) < 60);
      b    = randomBeat();
      applyStimulus(1'b0, 1'b0, 1'b1, b, ordy, 1'b1);
      checkAgainstModel("chaos", 1'b0, 1'b0);
      if (!inReady && model.size() < DEPTH) stallSeen++;
      wr = inReady;
      rd = ordy && (model.size() != 0);
      if (rd) void'(model.pop_front());
      if (wr) model.push_back(b);
    end
    checkOutput("chaos_stall_seen", 64'(stallSeen > 0), 64'(1));
    guard = 0;
    while (model.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1, 1'b1);
      checkAgainstModel("chaos_drain", 1'b0, 1'b0);
      void'(model.pop_front());
      guard++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, idle, 1'b1, 1'b1);
    checkOutput("chaos_final_empty", 64'(fifoEmpty), 64'(1));
`else
    stallSeen = 0;
    guard     = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
